// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [0:0] {
        SCAN = 1'b0,
        HOLD = 1'b1
    } scan_state_e;

    // Column 0 driven low, others released.
    localparam logic [3:0] COL_RESET = 4'b1110;

    // Indexed [row][col].
    localparam logic [3:0] KEYMAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

endpackage

// File: rtl/keypad_scanner_if.sv
// Pin and key-code bundle between the scanner, the keypad and its consumer.
interface keypad_scanner_if;

    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] keyDecoded;
    logic       keyPressed;

    modport master (
        input  rows,
        output cols,
        output keyDecoded,
        output keyPressed
    );

    modport slave (
        output rows,
        input  cols,
        input  keyDecoded,
        input  keyPressed
    );

endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer; resets to all ones to match idle pulled-up pins.
module sync2 #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner: rotates column drive, latches the first low row and
// holds it until that row releases. No debounce.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1000
) (
    input logic                clk,
    input logic                reset,
    keypad_scanner_if.master   bus
);

    localparam int unsigned        CNT_W   = $clog2(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(SETTLE_CYCLES - 1);

    logic [3:0]       rows_s;

    scan_state_e      state_q, state_d;
    logic [3:0]       cols_q, cols_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [1:0]       row_q, row_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       key_q, key_d;
    logic             pressed_q, pressed_d;

    logic             any_low;
    logic [1:0]       low_row;

    sync2 #(
        .WIDTH (4)
    ) u_row_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.rows),
        .q     (rows_s)
    );

    // Descending loop so the lowest low row wins.
    always_comb begin
        any_low = ~&rows_s;
        low_row = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows_s[i]) begin
                low_row = 2'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cols_d    = cols_q;
        col_idx_d = col_idx_q;
        row_d     = row_q;
        cnt_d     = cnt_q;
        key_d     = key_q;
        pressed_d = pressed_q;

        unique case (state_q)
            SCAN: begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d = '0;
                    if (any_low) begin
                        state_d   = HOLD;
                        row_d     = low_row;
                        key_d     = KEYMAP[low_row][col_idx_q];
                        pressed_d = 1'b1;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                        cols_d    = {cols_q[2:0], cols_q[3]};
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                // Any release of the latched row ends HOLD; rescan starts on the same column.
                if (rows_s[row_q]) begin
                    state_d   = SCAN;
                    pressed_d = 1'b0;
                    cnt_d     = '0;
                end
            end
            default: begin
                state_d = SCAN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= SCAN;
            cols_q    <= COL_RESET;
            col_idx_q <= 2'd0;
            row_q     <= 2'd0;
            cnt_q     <= '0;
            key_q     <= 4'h0;
            pressed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cols_q    <= cols_d;
            col_idx_q <= col_idx_d;
            row_q     <= row_d;
            cnt_q     <= cnt_d;
            key_q     <= key_d;
            pressed_q <= pressed_d;
        end
    end

    assign bus.cols       = cols_q;
    assign bus.keyDecoded = key_q;
    assign bus.keyPressed = pressed_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a passive 4x4 switch-matrix model.
module tb_keypad_scanner;

    logic        clk;
    logic        reset;
    logic [15:0] keys;       // keys[r*4+c] = switch at row r, column c closed
    logic [3:0]  rows_model;
    int          errors;
    int          checks;

    keypad_scanner_if bus ();

    keypad_scanner #(
        .SETTLE_CYCLES (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A closed switch pulls its row low only while its column is driven low.
    always_comb begin
        rows_model = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !bus.cols[c]) begin
                    rows_model[r] = 1'b0;
                end
            end
        end
    end
    assign bus.rows = rows_model;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic wait_kp(input logic lvl, input int budget, input string tag);
        int n;
        n = 0;
        while (bus.keyPressed !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(bus.keyPressed), 32'(lvl));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        logic [3:0] exp_cols;
        int         bad;
        errors = 0;
        checks = 0;
        keys   = '0;
        reset  = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_cols", 32'(bus.cols), 32'hE);
        check("rst_kp", 32'(bus.keyPressed), 32'h0);
        check("rst_kd", 32'(bus.keyDecoded), 32'h0);

        // Idle scan: each column held exactly 8 cycles
        reset = 1'b1;
        bad   = 0;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) @(negedge clk);
            exp_cols = ~(4'b0001 << ((k / 8) % 4));
            check("idle_cols", 32'(bus.cols), 32'(exp_cols));
            if (bus.keyPressed !== 1'b0) bad++;
        end
        check("idle_kp_low", 32'(bad), 32'h0);

        // Key 5: column 1 is driven from the next edge; detect at end of its window
        keys[1*4+1] = 1'b1;
        repeat (8) @(negedge clk);
        check("k5_before", 32'(bus.keyPressed), 32'h0);
        @(negedge clk);
        check("k5_kp", 32'(bus.keyPressed), 32'h1);
        check("k5_kd", 32'(bus.keyDecoded), 32'h5);
        check("k5_cols", 32'(bus.cols), 32'hD);
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (bus.cols !== 4'b1101 || bus.keyPressed !== 1'b1) bad++;
        end
        check("k5_frozen", 32'(bad), 32'h0);

        // Release: keyPressed falls on the 3rd edge, scanning resumes on column 1
        keys = '0;
        repeat (2) @(negedge clk);
        check("rel_kp_e2", 32'(bus.keyPressed), 32'h1);
        @(negedge clk);
        check("rel_kp_e3", 32'(bus.keyPressed), 32'h0);
        check("rel_kd_keep", 32'(bus.keyDecoded), 32'h5);
        check("rel_cols", 32'(bus.cols), 32'hD);
        repeat (7) @(negedge clk);
        check("rescan_col1_end", 32'(bus.cols), 32'hD);
        @(negedge clk);
        check("rescan_col2", 32'(bus.cols), 32'hB);

        // Rows 1001 in column 3: row 1 wins -> B
        keys[1*4+3] = 1'b1;
        keys[2*4+3] = 1'b1;
        wait_kp(1'b1, 100, "multi_kp");
        check("multi_kd", 32'(bus.keyDecoded), 32'hB);
        check("multi_cols", 32'(bus.cols), 32'h7);
        keys = '0;
        wait_kp(1'b0, 10, "multi_rel");

        // D latched, 1 pressed during overlap, then D released
        keys[3*4+3] = 1'b1;
        wait_kp(1'b1, 100, "d_kp");
        check("d_kd", 32'(bus.keyDecoded), 32'hD);
        keys[0*4+0] = 1'b1;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.keyPressed !== 1'b1 || bus.keyDecoded !== 4'hD || bus.cols !== 4'b0111) bad++;
        end
        check("d_overlap", 32'(bad), 32'h0);
        keys[3*4+3] = 1'b0;
        repeat (2) @(negedge clk);
        check("d_rel_e2", 32'(bus.keyPressed), 32'h1);
        @(negedge clk);
        check("d_rel_e3", 32'(bus.keyPressed), 32'h0);
        check("d_rel_kd", 32'(bus.keyDecoded), 32'hD);
        wait_kp(1'b1, 100, "k1_kp");
        check("k1_kd", 32'(bus.keyDecoded), 32'h1);
        check("k1_cols", 32'(bus.cols), 32'hE);

        // Key 9 held, then reset mid-HOLD
        keys[0*4+0] = 1'b0;
        wait_kp(1'b0, 10, "k1_rel");
        keys[2*4+2] = 1'b1;
        wait_kp(1'b1, 100, "k9_kp");
        check("k9_kd", 32'(bus.keyDecoded), 32'h9);
        check("k9_cols", 32'(bus.cols), 32'hB);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_cols", 32'(bus.cols), 32'hE);
        check("mid_rst_kp", 32'(bus.keyPressed), 32'h0);
        check("mid_rst_kd", 32'(bus.keyDecoded), 32'h0);
        @(negedge clk);
        check("mid_rst_cols2", 32'(bus.cols), 32'hE);
        reset = 1'b1;
        repeat (23) @(negedge clk);
        check("post_rst_before", 32'(bus.keyPressed), 32'h0);
        @(negedge clk);
        check("post_rst_kp", 32'(bus.keyPressed), 32'h1);
        check("post_rst_kd", 32'(bus.keyDecoded), 32'h9);
        check("post_rst_cols", 32'(bus.cols), 32'hB);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
